rsa_modexp_ctrl: RTL

Sequencer for the RSA32 modular-exponentiation path. It computes msg^exp mod N by left-to-right binary square-and-multiply. Each step is issued to an external modular multiplier through a start/done handshake; the multiplier holds N, and this block never sees it. The block sits between the IO/top level (start button, debug LEDs) and the multiplier, and also provides a per-operation watchdog and an operation counter for debug.

---
 rtl/rsa_modexp_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: sequencer for msg^exp mod N using left-to-right binary
// square-and-multiply. Each step goes to an external modular multiplier
// through a start/done handshake. The block also has a per-operation
// watchdog and a saturating count of multiplier operations.
module rsa_modexp_ctrl #(
   parameter int WIDTH   = 32,
   parameter int EXP_W   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] msg,
   input  logic [EXP_W-1:0] exp,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err,
   output logic [7:0]       mm_ops,
   output logic             mm_start,
   output logic [WIDTH-1:0] mm_a,
   output logic [WIDTH-1:0] mm_b,
   input  logic             mm_done,
   input  logic [WIDTH-1:0] mm_p
);

   localparam int CW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLIM    = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_TOP = CW'(EXP_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_SQ_REQ, S_SQ_WAIT, S_MUL_REQ, S_MUL_WAIT, S_FIN
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [EXP_W-1:0] e_q, e_d;
   // cnt holds the bit index of the exponent bit currently at e_q's MSB
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic             start_prev_q;
   logic [7:0]       ops_q, ops_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] mma_q, mma_d;
   logic [WIDTH-1:0] mmb_q, mmb_d;
   logic             accept;

   assign accept   = (state_q == S_IDLE) && start && !start_prev_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_FIN);
   assign result   = res_q;
   assign err      = err_q;
   assign mm_ops   = ops_q;
   assign mm_a     = mma_q;
   assign mm_b     = mmb_q;

   // State register and datapath registers; reset aborts any run in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         acc_q        <= '0;
         m_q          <= '0;
         e_q          <= '0;
         cnt_q        <= '0;
         tmr_q        <= '0;
         start_prev_q <= 1'b0;
         ops_q        <= '0;
         err_q        <= 1'b0;
         res_q        <= '0;
         mma_q        <= '0;
         mmb_q        <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         m_q          <= m_d;
         e_q          <= e_d;
         cnt_q        <= cnt_d;
         tmr_q        <= tmr_d;
         start_prev_q <= start;
         ops_q        <= ops_d;
         err_q        <= err_d;
         res_q        <= res_d;
         mma_q        <= mma_d;
         mmb_q        <= mmb_d;
      end
   end

   // Next-state logic: exponent scan, square/multiply sequencing, watchdog
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      m_d      = m_q;
      e_d      = e_q;
      cnt_d    = cnt_q;
      tmr_d    = tmr_q;
      ops_d    = ops_q;
      err_d    = err_q;
      res_d    = res_q;
      mma_d    = mma_q;
      mmb_d    = mmb_q;
      mm_start = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               m_d   = msg;
               e_d   = exp;
               cnt_d = CNT_TOP;
               ops_d = '0;
               err_d = 1'b0;
               if (exp == '0) begin
                  acc_d   = WIDTH'(1);
                  state_d = S_FIN;
               end else begin
                  state_d = S_SCAN;
               end
            end
         end
         S_SCAN: begin
            // skip leading zeros; the leading one seeds acc with the base
            e_d = e_q << 1;
            if (e_q[EXP_W-1]) begin
               acc_d = m_q;
               if (cnt_q == '0) begin
                  state_d = S_FIN;
               end else begin
                  cnt_d   = cnt_q - 1'b1;
                  state_d = S_SQ_REQ;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_SQ_REQ, S_MUL_REQ: begin
            mm_start = 1'b1;
            ops_d    = (ops_q == 8'hFF) ? ops_q : ops_q + 8'd1;
            tmr_d    = '0;
            state_d  = (state_q == S_SQ_REQ) ? S_SQ_WAIT : S_MUL_WAIT;
         end
         S_SQ_WAIT, S_MUL_WAIT: begin
            if (mm_done) begin
               acc_d = mm_p;
               if ((state_q == S_SQ_WAIT) && e_q[EXP_W-1]) begin
                  state_d = S_MUL_REQ;
               end else begin
                  // current bit fully processed; bit 0 ends the run
                  e_d = e_q << 1;
                  if (cnt_q == '0) begin
                     state_d = S_FIN;
                  end else begin
                     cnt_d   = cnt_q - 1'b1;
                     state_d = S_SQ_REQ;
                  end
               end
            end else if (tmr_q == TLIM) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // result becomes visible in the FIN cycle, alongside done
      if (state_d == S_FIN) begin
         res_d = acc_d;
      end
      // operands load on entry to REQ and hold through the matching WAIT
      if (state_d == S_SQ_REQ) begin
         mma_d = acc_d;
         mmb_d = acc_d;
      end else if (state_d == S_MUL_REQ) begin
         mma_d = acc_d;
         mmb_d = m_d;
      end
   end

endmodule
